ahb_lite_master: RTL
====================

Name: ahb_lite_master

Overview:
- Single-master AHB-Lite bus initiator sitting directly upstream of the address decoder and the two slaves.
- Drives HADDR and the other address/control signals that the decoder uses to generate HSELOne (HADDR[15:14]=0) and HSELTwo (HADDR[15:14]=1).
- Converts a simple local command (address, beat count, direction) into pipelined SINGLE or INCR word transfers.
- Returns read data, write-data requests and completion/error status to the local client.

Parameters:
- AddresseWidth, 32, HADDR and cmd_addr width
- DataWidth, 32, HWDATA/HRDATA width; fixed word transfers
- BeatWidth, 5, cmd_beats width; max burst 2^BeatWidth-1 beats
- TimeoutCycles, 256, wait-state limit (optional feature only)

Ports:
- HCLK  input  1  bus clock; all logic rising-edge
- HRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid&cmd_ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  AddresseWidth  start byte address; bits[1:0] ignored, forced 0
- cmd_beats  input  BeatWidth  beat count; 0 treated as 1
- wdata  input  DataWidth  write data; must be valid in the cycle wdata_req=1
- wdata_req  output  1  write beat address phase completes this cycle
- rd_data  output  DataWidth  read beat data
- rd_valid  output  1  one-cycle strobe per completed read beat
- done  output  1  one-cycle pulse at command end
- error  output  1  valid with done; 1 if any beat got HRESP=1
- HADDR  output  AddresseWidth  address
- HTRANS  output  2  IDLE=0, NONSEQ=2, SEQ=3; BUSY never used
- HWRITE  output  1  direction
- HSIZE  output  3  constant 3'b010
- HBURST  output  3  SINGLE=0 if 1 beat, INCR=1 otherwise
- HWDATA  output  DataWidth  registered write data
- HRDATA  input  DataWidth  muxed slave read data
- HREADY  input  1  transfer-complete / slave ready
- HRESP  input  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; HTRANS=0; HADDR=0; HWRITE=0; HBURST=0; HWDATA=0; cmd_ready=1; wdata_req/rd_valid/done/error=0. A reset mid-burst abandons the command with no done pulse.
- States:
  - IDLE: on accept, latch command and go to ADDR. First address phase is driven the next cycle with HTRANS=NONSEQ.
  - ADDR: address phases are being issued. Each cycle with HREADY=1 completes the current address phase; the next beat is then driven with HTRANS=SEQ and HADDR+4. After the last beat's address phase completes, go to DATA with HTRANS=IDLE.
  - DATA: last data phase is outstanding. On HREADY=1, pulse done and return to IDLE.
  - ERR: entered when HRESP=1 and HREADY=0. HTRANS is forced to IDLE that same cycle (the pending address phase is cancelled). On the next HREADY=1 (second error cycle), pulse done with error=1 and go to IDLE. No further beats are issued.
- Address, control and HTRANS hold stable while HREADY=0. Beat counter and address advance only on HREADY=1.
- Pipelining: beat n data phase overlaps beat n+1 address phase. A zero-wait-state N-beat command takes N+1 bus cycles from NONSEQ to the final HREADY, plus 1 cycle to the done pulse.
- Write: wdata_req=1 in the cycle a write address phase completes. wdata is registered into HWDATA and held through that beat's data phase.
- Read: rd_valid=1 and rd_data=HRDATA, registered on each read data phase completing with HREADY=1 and HRESP=0.
- 1KB boundary: if the incremented address has bits[9:0]=0, that beat is issued as NONSEQ (HBURST stays INCR).
- Address wrap past 2^AddresseWidth wraps to 0 modulo-width.
- done is asserted for exactly one cycle, and only in IDLE-return cycles. error=0 whenever done=0.

Optional Feature:
- AHB_MASTER_TIMEOUT_EN defined:
  - A counter increments each consecutive cycle HREADY=0 while a transfer is outstanding, and clears on HREADY=1.
  - On reaching TimeoutCycles, force HTRANS=IDLE, pulse done with error=1, and return to IDLE.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
- Single read at 0x0000_4008, HRDATA=0xCAFE_0001, no waits -> NONSEQ/SINGLE/HWRITE=0 on HADDR 0x4008 (HSELTwo region); rd_valid with 0xCAFE_0001; done=1, error=0 two cycles after NONSEQ.
- 4-beat write at 0x0000_0010, zero waits -> HADDR 0x10,0x14,0x18,0x1C with NONSEQ,SEQ,SEQ,SEQ; HBURST=INCR; four wdata_req pulses; HWDATA lags HADDR by one cycle; done after 5 bus cycles.
- 3-beat read at 0x3F8 -> HADDR 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ (1KB boundary).
- HREADY low 2 cycles during beat 2 of a 4-beat read -> HADDR/HTRANS held constant; 4 rd_valid total; done delayed by exactly 2 cycles.
- HRESP=1 (two-cycle error) on beat 2 of a 4-beat write -> HTRANS=IDLE in first error cycle; beats 3-4 never issued; done=1 with error=1.
- Assert HRESETn low mid-burst -> HTRANS=0 asynchronously; no done pulse; cmd_ready=1 after release. With AHB_MASTER_TIMEOUT_EN and TimeoutCycles=8, hold HREADY=0 -> done/error=1 after 8 cycles.

Source files
------------

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-master AHB-Lite initiator turning a local command into SINGLE/INCR word bursts.
// Optional wait-state timeout is compiled in when AHB_MASTER_TIMEOUT_EN is defined.
module ahb_lite_master #(
    parameter int AddresseWidth = 32,
    parameter int DataWidth     = 32,
    parameter int BeatWidth     = 5,
    parameter int TimeoutCycles = 256
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [AddresseWidth-1:0] cmd_addr,
    input  logic [BeatWidth-1:0]     cmd_beats,
    input  logic [DataWidth-1:0]     wdata,
    output logic                     wdata_req,
    output logic [DataWidth-1:0]     rd_data,
    output logic                     rd_valid,
    output logic                     done,
    output logic                     error,
    output logic [AddresseWidth-1:0] HADDR,
    output logic [1:0]               HTRANS,
    output logic                     HWRITE,
    output logic [2:0]               HSIZE,
    output logic [2:0]               HBURST,
    output logic [DataWidth-1:0]     HWDATA,
    input  logic [DataWidth-1:0]     HRDATA,
    input  logic                     HREADY,
    input  logic                     HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    state_t                   r_state;
    logic [1:0]               r_trans;
    logic [BeatWidth-1:0]     r_beats_left;
    logic                     r_dphase;
    logic [AddresseWidth-1:0] w_next_addr;
    logic                     w_err_now;
    logic                     w_addr_done;
    logic                     w_rd_done;
    logic                     w_timeout;

    assign w_next_addr = HADDR + AddresseWidth'(4);
    assign w_err_now   = r_dphase & HRESP & ~HREADY;
    assign w_addr_done = (r_state == S_ADDR) & HREADY;
    assign w_rd_done   = r_dphase & ~HWRITE & HREADY & ~HRESP;

    // NOTE: HTRANS is muxed combinationally so the first error cycle can cancel the pending address phase.
    assign HTRANS    = w_err_now ? TransIdle : r_trans;
    assign cmd_ready = (r_state == S_IDLE);
    assign wdata_req = w_addr_done & HWRITE;
    assign HSIZE     = 3'b010;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] r_wait_cnt;

    assign w_timeout = (r_state != S_IDLE) & ~HREADY & (r_wait_cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait_cnt <= '0;
        end else if (HREADY || (r_state == S_IDLE) || w_timeout) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TimeoutCycles != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_trans      <= TransIdle;
            r_beats_left <= '0;
            r_dphase     <= 1'b0;
            HADDR        <= '0;
            HWRITE       <= 1'b0;
            HBURST       <= 3'b000;
            HWDATA       <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            if (wdata_req) begin
                HWDATA <= wdata;
            end
            if (w_rd_done) begin
                rd_valid <= 1'b1;
                rd_data  <= HRDATA;
            end
            if (w_timeout) begin
                r_state  <= S_IDLE;
                r_trans  <= TransIdle;
                r_dphase <= 1'b0;
                done     <= 1'b1;
                error    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            r_state  <= S_ADDR;
                            r_trans  <= TransNonseq;
                            r_dphase <= 1'b0;
                            HADDR    <= cmd_addr & ~AddresseWidth'(3);
                            HWRITE   <= cmd_write;
                            if (cmd_beats <= BeatWidth'(1)) begin
                                r_beats_left <= BeatWidth'(1);
                                HBURST       <= 3'b000;
                            end else begin
                                r_beats_left <= cmd_beats;
                                HBURST       <= 3'b001;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_err_now) begin
                            r_state <= S_ERR;
                            r_trans <= TransIdle;
                        end else if (HREADY) begin
                            r_dphase <= 1'b1;
                            if (r_beats_left == BeatWidth'(1)) begin
                                r_state <= S_DATA;
                                r_trans <= TransIdle;
                            end else begin
                                r_beats_left <= r_beats_left - 1'b1;
                                HADDR        <= w_next_addr;
                                // A new 1KB page must restart the burst with NONSEQ.
                                r_trans      <= (w_next_addr[9:0] == 10'd0) ? TransNonseq : TransSeq;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_err_now) begin
                            r_state <= S_ERR;
                        end else if (HREADY) begin
                            r_state  <= S_IDLE;
                            r_dphase <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    S_ERR: begin
                        if (HREADY) begin
                            r_state  <= S_IDLE;
                            r_dphase <= 1'b0;
                            done     <= 1'b1;
                            error    <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
